fword_ctrl: RTL and testbench

FWORD_CTRL -- requirements
Module: fword_ctrl

---
 rtl/fword_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fword_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fword_ctrl.sv
// fword_ctrl: selects a DDS phase-increment word (three presets or a
// stepped sweep) from a VIO mode key and hands each new word to the DDS
// config channel through a valid/ready handshake with a 1-deep pending slot.
module fword_ctrl #(
  parameter int                 FWORD_W   = 24,
  parameter logic [FWORD_W-1:0] F_PRESET0 = 24'd16777,
  parameter logic [FWORD_W-1:0] F_PRESET1 = 24'd167772,
  parameter logic [FWORD_W-1:0] F_PRESET2 = 24'd1677721,
  parameter logic [FWORD_W-1:0] F_MIN     = 24'd16777,
  parameter logic [FWORD_W-1:0] F_MAX     = 24'd1677721,
  parameter logic [FWORD_W-1:0] F_STEP    = 24'd16777,
  parameter int                 DWELL     = 50000
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [1:0]         key_PINC,
  output logic               m_axis_config_tvalid,
  input  logic               m_axis_config_tready,
  output logic [FWORD_W-1:0] m_axis_config_tdata,
  output logic [FWORD_W-1:0] fword,
  output logic               sweep_wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'b00,
    S_IDLE = 2'b01,
    S_SEND = 2'b10
  } state_t;

  logic [1:0]         key_meta_q;
  logic [1:0]         key_s_q;
  logic [FWORD_W-1:0] sweep_q, sweep_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic               wrap_q, wrap_d;
  logic [FWORD_W:0]   sum_s;
  logic [FWORD_W-1:0] target_s;
  logic [FWORD_W-1:0] fword_q;
  logic               change_s;
  state_t             state_q, state_d;
  logic [FWORD_W-1:0] tdata_q, tdata_d;
  logic               pending_q, pending_d;
  logic               tvalid_q, tvalid_d;

  // Two-flop synchronizer for the asynchronous VIO key.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 2'b00;
      key_s_q    <= 2'b00;
    end else begin
      key_meta_q <= key_PINC;
      key_s_q    <= key_meta_q;
    end
  end

  // Sum is one bit wider so a carry-out also counts as passing F_MAX.
  assign sum_s = {1'b0, sweep_q} + {1'b0, F_STEP};

  // Sweep next state: held at F_MIN outside mode 11, so every entry restarts.
  always_comb begin
    sweep_d = sweep_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    if (key_s_q != 2'b11) begin
      sweep_d = F_MIN;
      dwell_d = '0;
    end else if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      if (sum_s > {1'b0, F_MAX}) begin
        sweep_d = F_MIN;
        wrap_d  = 1'b1;
      end else begin
        sweep_d = sum_s[FWORD_W-1:0];
      end
    end else begin
      dwell_d = dwell_q + CNT_W'(1);
    end
  end

  // Sweep register, dwell counter and wrap pulse.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_q <= F_MIN;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      sweep_q <= sweep_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
    end
  end

  // Target word selected by the synchronized mode.
  always_comb begin
    target_s = F_PRESET0;
    case (key_s_q)
      2'b00:   target_s = F_PRESET0;
      2'b01:   target_s = F_PRESET1;
      2'b10:   target_s = F_PRESET2;
      2'b11:   target_s = sweep_q;
      default: target_s = F_PRESET0;
    endcase
  end

  // fword changes on the next edge whenever the target differs from it.
  assign change_s = (target_s != fword_q);

  // Handshake FSM next state; tdata always loads the word fword is taking.
  always_comb begin
    state_d   = state_q;
    tdata_d   = tdata_q;
    pending_d = pending_q;
    case (state_q)
      S_INIT: begin
        state_d   = S_SEND;
        tdata_d   = target_s;
        pending_d = 1'b0;
      end
      S_IDLE: begin
        if (change_s) begin
          state_d = S_SEND;
          tdata_d = target_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (m_axis_config_tready) begin
          if (pending_q || change_s) begin
            // Reissue the latest word right after the accepted one.
            state_d   = S_SEND;
            tdata_d   = target_s;
            pending_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          // Stalled: keep tdata stable, remember that a newer word exists.
          if (change_s) begin
            pending_d = 1'b1;
          end else begin
            pending_d = pending_q;
          end
        end
      end
      default: begin
        state_d   = S_INIT;
        tdata_d   = '0;
        pending_d = 1'b0;
      end
    endcase
    tvalid_d = (state_d == S_SEND);
  end

  // FSM state, output word, pending flag and registered tvalid.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      tdata_q   <= '0;
      pending_q <= 1'b0;
      tvalid_q  <= 1'b0;
      fword_q   <= '0;
    end else begin
      state_q   <= state_d;
      tdata_q   <= tdata_d;
      pending_q <= pending_d;
      tvalid_q  <= tvalid_d;
      fword_q   <= target_s;
    end
  end

  assign m_axis_config_tvalid = tvalid_q;
  assign m_axis_config_tdata  = tdata_q;
  assign fword                = fword_q;
  assign sweep_wrap           = wrap_q;

endmodule

// File: tb/tb_fword_ctrl.sv
// Bench for fword_ctrl: directed key/tready sequences, expected transfers
// queued at stimulus time and checked by an independent handshake monitor.
module tb_fword_ctrl;

  logic        sys_clk;
  logic        rst_n;
  logic [1:0]  key_PINC;
  logic        tvalid;
  logic        tready;
  logic [23:0] tdata;
  logic [23:0] fword;
  logic        sweep_wrap;

  int total;
  int bad;
  int cyc;
  int n_tx;
  int wrap_hi;
  logic [23:0] exp_q[$];
  int          tx_cyc[$];

  fword_ctrl #(
    .DWELL (4),
    .F_STEP(24'd1000),
    .F_MIN (24'd0),
    .F_MAX (24'd2500)
  ) dut (
    .sys_clk             (sys_clk),
    .rst_n               (rst_n),
    .key_PINC            (key_PINC),
    .m_axis_config_tvalid(tvalid),
    .m_axis_config_tready(tready),
    .m_axis_config_tdata (tdata),
    .fword               (fword),
    .sweep_wrap          (sweep_wrap)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Monitor: every accepted transfer pops and checks the next expected word.
  always @(negedge sys_clk) begin
    cyc++;
    if (rst_n && tvalid && tready) begin
      n_tx++;
      tx_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL xfer_unexpected: got %0d expected none", tdata);
      end else begin
        chk("xfer_data", int'(tdata), int'(exp_q.pop_front()));
      end
    end
    if (sweep_wrap) wrap_hi++;
  end

  initial begin
    int n0, w0, c0;
    total = 0; bad = 0; cyc = 0; n_tx = 0; wrap_hi = 0;
    rst_n = 1'b0; key_PINC = 2'b00; tready = 1'b1;

    // Reset values
    #12;
    chk("rst_tvalid", int'(tvalid), 0);
    chk("rst_tdata", int'(tdata), 0);
    chk("rst_fword", int'(fword), 0);
    chk("rst_wrap", int'(sweep_wrap), 0);

    // Release with key 00: exactly one transfer of preset 0
    exp_q.push_back(24'd16777);
    c0 = n_tx;
    @(posedge sys_clk); #1; rst_n = 1'b1;
    step(10);
    chk("boot_count", n_tx - c0, 1);
    chk("boot_tvalid_low", int'(tvalid), 0);
    chk("boot_fword", int'(fword), 16777);

    // key 00 -> 01: one transfer within 4 cycles
    c0 = n_tx;
    key_PINC = 2'b01; exp_q.push_back(24'd167772);
    step(4);
    chk("k01_latency", n_tx - c0, 1);
    step(4);
    chk("k01_count", n_tx - c0, 1);
    chk("k01_tvalid_low", int'(tvalid), 0);

    // Stall 20 cycles while key goes 01 -> 10 -> 00
    c0 = n_tx;
    tready = 1'b0;
    key_PINC = 2'b10; exp_q.push_back(24'd1677721);
    step(5);
    key_PINC = 2'b00; exp_q.push_back(24'd16777);
    step(15);
    chk("stall_tvalid", int'(tvalid), 1);
    chk("stall_tdata", int'(tdata), 1677721);
    tready = 1'b1;
    step(10);
    chk("stall_count", n_tx - c0, 2);
    chk("stall_tvalid_low", int'(tvalid), 0);

    // Handshake on the same edge as the fword change
    c0 = n_tx;
    tready = 1'b0;
    key_PINC = 2'b01; exp_q.push_back(24'd167772);
    step(6);
    key_PINC = 2'b10; exp_q.push_back(24'd1677721);
    step(2);
    tready = 1'b1;
    step(1);
    chk("same_edge_tvalid", int'(tvalid), 1);
    chk("same_edge_tdata", int'(tdata), 1677721);
    step(5);
    chk("same_edge_count", n_tx - c0, 2);

    // Sweep: 0, 1000, 2000, wrap to 0, then leave to mode 00
    n0 = tx_cyc.size();
    w0 = wrap_hi;
    key_PINC = 2'b11;
    exp_q.push_back(24'd0);
    exp_q.push_back(24'd1000);
    exp_q.push_back(24'd2000);
    exp_q.push_back(24'd0);
    step(15);
    key_PINC = 2'b00; exp_q.push_back(24'd16777);
    step(10);
    chk("sweep_count", tx_cyc.size() - n0, 5);
    if (tx_cyc.size() - n0 >= 4) begin
      for (int i = 0; i < 3; i++)
        chk("sweep_gap", tx_cyc[n0 + i + 1] - tx_cyc[n0 + i], 4);
    end
    chk("sweep_wrap_cycles", wrap_hi - w0, 1);

    // Reset mid-send: tvalid drops at once, boot sequence repeats
    tready = 1'b0;
    key_PINC = 2'b01;
    step(6);
    chk("pre_rst_tvalid", int'(tvalid), 1);
    #3; rst_n = 1'b0; #1;
    chk("async_rst_tvalid", int'(tvalid), 0);
    chk("async_rst_tdata", int'(tdata), 0);
    key_PINC = 2'b00; tready = 1'b1;
    c0 = n_tx;
    exp_q.push_back(24'd16777);
    @(posedge sys_clk); #1; rst_n = 1'b1;
    step(10);
    chk("reboot_count", n_tx - c0, 1);
    chk("reboot_tvalid_low", int'(tvalid), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
